// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, retry and system reset release
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          restart,
    output logic          pll_rst,
    output logic          sys_rst_out,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_count,
    output logic [7:0]    relock_count
);

    localparam int TMAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > LOCK_STABLE_CYCLES) ? TMAX_A : LOCK_STABLE_CYCLES;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [7:0]             relock_q, relock_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lk;

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};

        // restart outranks every other transition, including lock loss in RUN
        if (restart) begin
            state_d = S_RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state_d = S_STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_RESET_PLL;
                            retry_d = retry_q + RW'(1);
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_STABILIZE: begin
                    if (!lk) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state_d = S_RESET_PLL;
                        timer_d = '0;
                        retry_d = '0;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end

        // Moore outputs are decoded from the next state so they land with it
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst_out  = sys_rst_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed vector bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst_out;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] relock_count;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .SYNC_STAGES        (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .sys_rst_out (sys_rst_out),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .relock_count(relock_count)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string       name;
        logic        r;
        logic        lk;
        logic        rs;
        int          n;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input string name, input logic r, input logic lk, input logic rs,
                                input int n, input logic p, input logic s, input logic rd,
                                input logic f, input logic [1:0] rt, input logic [7:0] rl);
        vec_t v;
        v.name = name;
        v.r    = r;
        v.lk   = lk;
        v.rs   = rs;
        v.n    = n;
        v.exp  = {p, s, rd, f, rt, rl};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {pll_rst, sys_rst_out, ready, fault, retry_count, relock_count};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d relock=%0d, expected pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d relock=%0d",
                     name, act[13], act[12], act[11], act[10], act[9:8], act[7:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge refclk);
        rst        = v.r;
        pll_locked = v.lk;
        restart    = v.rs;
        repeat (v.n) @(posedge refclk);
        #1;
        check(v.name, v.exp);
    endtask

    initial begin
        //   name              rst lk rs  n  prst sys rdy flt rt  rl
        add("reset_state",      1, 0, 0,  0, 1,   1,  0,  0,  0,  0);
        add("bringup_pulse_hi", 0, 0, 0,  3, 1,   1,  0,  0,  0,  0);
        add("bringup_pulse_lo", 0, 0, 0,  1, 0,   1,  0,  0,  0,  0);
        add("bringup_wait",     0, 0, 0, 10, 0,   1,  0,  0,  0,  0);
        add("bringup_edge10",   0, 1, 0, 10, 0,   1,  0,  0,  0,  0);
        add("bringup_ready",    0, 1, 0,  1, 0,   0,  1,  0,  0,  0);
        add("loss_edge2",       0, 0, 0,  2, 0,   0,  1,  0,  0,  0);
        add("loss_edge3",       0, 0, 0,  1, 1,   1,  0,  0,  0,  1);
        add("relock_pulse_hi",  0, 0, 0,  3, 1,   1,  0,  0,  0,  1);
        add("relock_pulse_lo",  0, 0, 0,  1, 0,   1,  0,  0,  0,  1);
        add("relock_edge10",    0, 1, 0, 10, 0,   1,  0,  0,  0,  1);
        add("relock_run",       0, 1, 0,  1, 0,   0,  1,  0,  0,  1);
        add("glitch_loss",      0, 0, 0,  3, 1,   1,  0,  0,  0,  2);
        add("glitch_pulse",     0, 0, 0,  4, 0,   1,  0,  0,  0,  2);
        add("glitch_stab5",     0, 1, 0,  7, 0,   1,  0,  0,  0,  2);
        add("glitch_drop",      0, 0, 0,  1, 0,   1,  0,  0,  0,  2);
        add("glitch_no_early",  0, 1, 0, 10, 0,   1,  0,  0,  0,  2);
        add("glitch_ready",     0, 1, 0,  1, 0,   0,  1,  0,  0,  2);
        add("nolock_pulse1_hi", 0, 0, 0,  3, 1,   1,  0,  0,  0,  3);
        add("nolock_pulse1_lo", 0, 0, 0,  4, 0,   1,  0,  0,  0,  3);
        add("nolock_wait1",     0, 0, 0, 31, 0,   1,  0,  0,  0,  3);
        add("nolock_retry1",    0, 0, 0,  1, 1,   1,  0,  0,  1,  3);
        add("nolock_pulse2_hi", 0, 0, 0,  3, 1,   1,  0,  0,  1,  3);
        add("nolock_pulse2_lo", 0, 0, 0,  1, 0,   1,  0,  0,  1,  3);
        add("nolock_wait2",     0, 0, 0, 31, 0,   1,  0,  0,  1,  3);
        add("nolock_retry2",    0, 0, 0,  1, 1,   1,  0,  0,  2,  3);
        add("nolock_pulse3_lo", 0, 0, 0,  4, 0,   1,  0,  0,  2,  3);
        add("nolock_wait3",     0, 0, 0, 31, 0,   1,  0,  0,  2,  3);
        add("nolock_fault",     0, 0, 0,  1, 1,   1,  0,  1,  2,  3);
        add("fault_absorbing",  0, 0, 0, 20, 1,   1,  0,  1,  2,  3);
        add("fault_restart",    0, 0, 1,  1, 1,   1,  0,  0,  0,  3);
        add("restart_pulse_hi", 0, 0, 0,  3, 1,   1,  0,  0,  0,  3);
        add("restart_pulse_lo", 0, 0, 0,  1, 0,   1,  0,  0,  0,  3);
        add("restart_run",      0, 1, 0, 11, 0,   0,  1,  0,  0,  3);
        add("simul_pre",        0, 0, 0,  2, 0,   0,  1,  0,  0,  3);
        add("simul_restart",    0, 0, 1,  1, 1,   1,  0,  0,  0,  3);
        add("simul_pulse_hi",   0, 0, 0,  3, 1,   1,  0,  0,  0,  3);
        add("simul_pulse_lo",   0, 0, 0,  1, 0,   1,  0,  0,  0,  3);
        add("simul_run",        0, 1, 0, 11, 0,   0,  1,  0,  0,  3);
        add("loss4",            0, 0, 0,  3, 1,   1,  0,  0,  0,  4);
        add("loss4_pulse",      0, 0, 0,  4, 0,   1,  0,  0,  0,  4);
        add("loss4_run",        0, 1, 0, 11, 0,   0,  1,  0,  0,  4);
        add("loss5",            0, 0, 0,  3, 1,   1,  0,  0,  0,  5);
        add("loss5_pulse",      0, 0, 0,  4, 0,   1,  0,  0,  0,  5);
        add("loss5_run",        0, 1, 0, 11, 0,   0,  1,  0,  0,  5);

        foreach (tbl[i]) apply(tbl[i]);

        // asynchronous reset between edges while in RUN with relock_count=5
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_immediate", {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
        repeat (3) @(posedge refclk);
        #1;
        check("async_rst_held", {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
        @(negedge refclk);
        rst        = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        check("post_rst_pulse_hi", {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
        @(posedge refclk);
        #1;
        check("post_rst_pulse_lo", {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
